rv32i_dmem_responder: RTL and testbench

RV32I_DMEM_RESPONDER -- requirements
Module: rv32i_dmem_responder

---
 rtl/rv32i_dmem_responder.sv | 130 +++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: RV32I data-memory responder with a configurable wait state.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr, req_we, req_size   byte address, store flag, 0=B 1=H 2=W 3=illegal
//   req_unsigned, req_wdata      load zero-extension, right-aligned store data
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           extended load data, error flag
module rv32i_dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [1:0]  r_size;
    logic        r_we, r_uns, r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_direct, w_req_err, w_go_resp, w_write;
    logic          w_acc_we, w_acc_err;
    logic [1:0]    w_acc_size;
    logic [31:0]   w_acc_addr, w_acc_wdata, w_off, w_wd, w_fmt;
    logic [3:0]    w_be;
    logic [15:0]   w_sh;
    logic [AW-1:0] w_idx;

    function automatic logic f_err(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
            || ({1'b0, off} >= LIMIT);
    endfunction

    assign w_accept  = req_valid && r_state == S_IDLE;
    assign w_req_err = f_err(req_addr, req_size);

    // With no wait state the RAM access happens on the accepting edge itself,
    // so it must use the live request rather than the captured copy.
    assign w_direct    = r_state == S_IDLE;
    assign w_acc_addr  = w_direct ? req_addr  : r_addr;
    assign w_acc_wdata = w_direct ? req_wdata : r_wdata;
    assign w_acc_size  = w_direct ? req_size  : r_size;
    assign w_acc_we    = w_direct ? req_we    : r_we;
    assign w_acc_err   = w_direct ? w_req_err : r_err;

    // reset_n gating keeps a request presented during reset from touching storage
    assign w_go_resp = reset_n && ((w_accept && WAIT_CYCLES == 0) || (r_state == S_WAIT && r_cnt == 4'd0));
    assign w_write   = w_go_resp && w_acc_we && !w_acc_err;
    assign w_off     = w_acc_addr - BASE_ADDR;
    assign w_idx     = AW'(w_off >> 2);
    assign w_be      = w_acc_size == 2'd0 ? 4'b0001 << w_acc_addr[1:0]
                     : w_acc_size == 2'd1 ? (w_acc_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd      = w_acc_size == 2'd0 ? {4{w_acc_wdata[7:0]}}
                     : w_acc_size == 2'd1 ? {2{w_acc_wdata[15:0]}} : w_acc_wdata;

    // single-port RAM: one byte-enabled write or one registered read per access
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
        end else if (w_go_resp) begin
            r_rd <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_size  <= 2'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= w_req_err;
            end
            r_cnt <= w_accept ? (WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0)
                   : (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sh  = 16'(r_rd >> {r_addr[1:0], 3'b000});
    assign w_fmt = r_size == 2'd0 ? {{24{!r_uns && w_sh[7]}}, w_sh[7:0]}
                 : r_size == 2'd1 ? {{16{!r_uns && w_sh[15]}}, w_sh[15:0]} : r_rd;

    assign req_ready = r_state == S_IDLE;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_fmt : 32'h0;
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb_rv32i_dmem_responder: checks three responders (WAIT_CYCLES 1, 3, 0) against directed vectors and a byte-level model.
module tb_rv32i_dmem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          SPAN = 4096 * 4;

    logic        clk = 1'b0;
    logic        reset_n      [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic [31:0] req_addr     [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32i_dmem_responder #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 0)) u_dut (
            .clk(clk), .reset_n(reset_n[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
            .req_we(req_we[g]), .req_size(req_size[g]), .req_unsigned(req_unsigned[g]),
            .req_wdata(req_wdata[g]), .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    typedef struct {
        string       nm;
        bit          we;
        bit [1:0]    sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    int       n_vec = 0;
    int       n_bad = 0;
    bit [7:0] mb [SPAN];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input bit [1:0] s);
        logic [31:0] off;
        off = a - BASE;
        return s == 3 || (s == 1 && a[0]) || (s == 2 && a[1:0] != 0) || off >= SPAN;
    endfunction

    function automatic void m_store(input logic [31:0] a, input bit [1:0] s, input logic [31:0] wd);
        int off;
        off = int'(a - BASE);
        for (int k = 0; k < (1 << s); k++) mb[off + k] = wd[8*k +: 8];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input bit [1:0] s, input bit uns);
        int          off;
        int          nb;
        logic [31:0] v;
        off = int'(a - BASE);
        nb  = 1 << s;
        v   = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(mb[off + k]) << (8 * k));
        if (!uns && nb < 4 && v[8*nb-1]) v = v - (32'h1 << (8 * nb));
        return v;
    endfunction

    task automatic check_idle(input int d, input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready[d]), 32'h1);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid[d]), 32'h0);
        chk({nm, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
        chk({nm, "_rsp_err"}, 32'(rsp_err[d]), 32'h0);
    endtask

    task automatic do_req(input int d, input bit we, input bit [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d] = a; req_wdata[d] = wd; rsp_ready[d] = (hold == 0);
        chk("req_ready_pre", 32'(req_ready[d]), 32'h1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_we[d]    = 1'($urandom);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid[d]) begin
            chk("rsp_timeout", 32'h0, 32'h1);
            rd = 32'hx; er = 1'bx;
        end else begin
            rd = rsp_rdata[d]; er = rsp_err[d];
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(rsp_valid[d]), 32'h1);
                chk("hold_rdata", rsp_rdata[d], rd);
                chk("hold_err", 32'(rsp_err[d]), 32'(er));
                chk("hold_req_ready", 32'(req_ready[d]), 32'h0);
            end
            if (hold > 0) begin
                @(negedge clk);
                rsp_ready[d] = 1'b1;
            end
            @(posedge clk); #1;
            check_idle(d, "post_rsp");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd;
        logic        er;
        int          lat;

        for (int d = 0; d < 3; d++) begin
            reset_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "in_reset");
        for (int d = 0; d < 3; d++) reset_n[d] = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) check_idle(d, "after_reset");

        tbl.push_back('{"sw_10",      1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        tbl.push_back('{"lw_10",      1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{"sb_13",      1'b1, 2'd0, 1'b0, 32'h8000_0013, 32'h1234_5680, 32'h0000_0000, 1'b0});
        tbl.push_back('{"lb_13",      1'b0, 2'd0, 1'b0, 32'h8000_0013, 32'h0,         32'hFFFF_FF80, 1'b0});
        tbl.push_back('{"lbu_13",     1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0,         32'h0000_0080, 1'b0});
        tbl.push_back('{"lw_10_sb",   1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h80AD_BEEF, 1'b0});
        tbl.push_back('{"lh_11_mis",  1'b0, 2'd1, 1'b0, 32'h8000_0011, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{"sw_12_mis",  1'b1, 2'd2, 1'b0, 32'h8000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1});
        tbl.push_back('{"lw_below",   1'b0, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{"lw_10_keep", 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h80AD_BEEF, 1'b0});
        tbl.push_back('{"size3",      1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{"sw_last",    1'b1, 2'd2, 1'b0, 32'h8000_3FFC, 32'h0102_0304, 32'h0000_0000, 1'b0});
        tbl.push_back('{"lw_last",    1'b0, 2'd2, 1'b0, 32'h8000_3FFC, 32'h0,         32'h0102_0304, 1'b0});
        tbl.push_back('{"lw_end",     1'b0, 2'd2, 1'b0, 32'h8000_4000, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{"sb_end",     1'b1, 2'd0, 1'b0, 32'h8000_4000, 32'h0000_00FF, 32'h0000_0000, 1'b1});
        tbl.push_back('{"sh_16",      1'b1, 2'd1, 1'b0, 32'h8000_0016, 32'hABCD_8001, 32'h0000_0000, 1'b0});
        tbl.push_back('{"lh_16",      1'b0, 2'd1, 1'b0, 32'h8000_0016, 32'h0,         32'hFFFF_8001, 1'b0});
        tbl.push_back('{"lhu_16",     1'b0, 2'd1, 1'b1, 32'h8000_0016, 32'h0,         32'h0000_8001, 1'b0});
        tbl.push_back('{"sb_11",      1'b1, 2'd0, 1'b0, 32'h8000_0011, 32'h0000_007F, 32'h0000_0000, 1'b0});
        tbl.push_back('{"lw_10_sb11", 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h80AD_7FEF, 1'b0});
        tbl.push_back('{"lb_12",      1'b0, 2'd0, 1'b0, 32'h8000_0012, 32'h0,         32'hFFFF_FFAD, 1'b0});
        tbl.push_back('{"lh_12",      1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,         32'hFFFF_80AD, 1'b0});
        tbl.push_back('{"lhu_12",     1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0,         32'h0000_80AD, 1'b0});

        foreach (tbl[i]) begin
            do_req(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, 0, rd, er, lat);
            chk({tbl[i].nm, "_rdata"}, rd, tbl[i].exp_rd);
            chk({tbl[i].nm, "_err"}, 32'(er), 32'(tbl[i].exp_err));
            chk({tbl[i].nm, "_latency"}, 32'(lat), 32'd2);
        end

        do_req(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 5, rd, er, lat);
        chk("hold5_rdata", rd, 32'h80AD_7FEF);
        chk("hold5_err", 32'(er), 32'h0);

        do_req(1, 1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'hCAFE_F00D, 0, rd, er, lat);
        chk("w3_sw_latency", 32'(lat), 32'd4);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 0, rd, er, lat);
        chk("w3_lw_rdata", rd, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h8000_0020; req_wdata[1] = 32'h1234_5678; rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("w3_wait_req_ready", 32'(req_ready[1]), 32'h0);
        chk("w3_wait_rsp_valid", 32'(rsp_valid[1]), 32'h0);
        @(negedge clk);
        reset_n[1] = 1'b0;
        #1;
        check_idle(1, "w3_mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n[1] = 1'b1;
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 0, rd, er, lat);
        chk("w3_after_reset_rdata", rd, 32'hCAFE_F00D);
        chk("w3_after_reset_latency", 32'(lat), 32'd4);

        do_req(2, 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h5A5A_A5A5, 0, rd, er, lat);
        chk("w0_sh_latency", 32'(lat), 32'd1);
        chk("w0_sh_err", 32'(er), 32'h0);
        do_req(2, 1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 0, rd, er, lat);
        chk("w0_lhu_rdata", rd, 32'h0000_A5A5);
        chk("w0_lhu_latency", 32'(lat), 32'd1);
        do_req(2, 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 0, rd, er, lat);
        chk("w0_lh_rdata", rd, 32'hFFFF_A5A5);
        do_req(2, 1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'hFFFF_FFFF, 0, rd, er, lat);
        chk("w0_sw_mis_err", 32'(er), 32'h1);
        chk("w0_sw_mis_latency", 32'(lat), 32'd1);
        do_req(2, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 0, rd, er, lat);
        chk("w0_lw_rdata_hi", 32'(rd[31:16]), 32'h0000_A5A5);

        for (int w = 0; w < 32; w++) begin
            logic [31:0] a;
            logic [31:0] wd;
            a  = BASE + 32'(4 * (w < 16 ? w : 4064 + w));
            wd = $urandom;
            do_req(0, 1'b1, 2'd2, 1'b0, a, wd, 0, rd, er, lat);
            m_store(a, 2'd2, wd);
            chk("init_err", 32'(er), 32'h0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            bit [1:0]    sz;
            bit          we;
            bit          uns;
            bit          e;
            int          r;
            r   = $urandom_range(0, 2);
            a   = r == 0 ? BASE + 32'($urandom_range(0, 63))
                : r == 1 ? BASE + 32'(16320 + $urandom_range(0, 127))
                : BASE - 32'($urandom_range(1, 16));
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom);
            uns = 1'($urandom);
            wd  = $urandom;
            e   = m_err(a, sz);
            exp_rd = 32'h0;
            if (!e && we) m_store(a, sz, wd);
            if (!e && !we) exp_rd = m_load(a, sz, uns);
            do_req(0, we, sz, uns, a, wd, $urandom_range(0, 2), rd, er, lat);
            chk($sformatf("rnd%0d_rdata a=%h sz=%0d we=%0d", n, a, sz, we), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
